uart_ahb_bridge: RTL and testbench

//  Serial debug/loader master: receives command packets on rx_pin (8N1, LSB first), issues one AHB

---
 rtl/uart_ahb_bridge.sv | 319 +++++++++++++++++++++++++++++++
 tb/tb_uart_ahb_bridge.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_ahb_bridge.sv
// uart_ahb_bridge: serial debug/loader master for the AHB bus.
//   Takes command packets on rx_pin (8N1, LSB first), runs one single AHB transfer per
//   packet and answers on tx_pin with a status byte (plus read data for reads).
//   Packet: opcode (0xA5 write / 0x5A read), 4 address bytes LSB first, and for writes
//   4 data bytes LSB first. Unknown opcode -> single 0x45 reply.
// Ports:
//   clk, rstn        system clock, asynchronous active-low reset
//   rx_pin / tx_pin  serial command in / response out, both idle high
//   hsel, hwrite,    address phase request (hsel is a one-cycle pulse)
//   haddr, hwdata    address held through the data phase, write data in data phase
//   hready, hresp,   data phase completion, error flag and read data
//   hrdata
// Optional feature: define UART_BRIDGE_TIMEOUT_EN to drop a partial packet after
//   16 idle bit times between bytes; without it a partial packet waits forever.
// The protocol carries exactly four address and four data bytes, so ADDR_W and
// DATA_W are expected to stay at 32.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for an opcode byte
// S_ADDR  | collecting 4 address bytes
// S_WDATA | collecting 4 write data bytes (write only)
// S_AHB_A | address phase, hsel high for one cycle
// S_AHB_D | data phase, waiting for hready
// S_RESP  | response bytes draining through the transmitter

`ifndef CLK_FRE
`define CLK_FRE 50
`endif
`ifndef BAUD_RATE
`define BAUD_RATE 115200
`endif
`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif
`ifndef AHB_DATA_WIDTH
`define AHB_DATA_WIDTH 32
`endif

module uart_ahb_bridge #(
    parameter int CLK_MHZ = `CLK_FRE,
    parameter int BAUD    = `BAUD_RATE,
    parameter int ADDR_W  = `AHB_ADDR_WIDTH,
    parameter int DATA_W  = `AHB_DATA_WIDTH
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rx_pin,
    output logic              tx_pin,
    output logic              hsel,
    output logic              hwrite,
    output logic [ADDR_W-1:0] haddr,
    output logic [DATA_W-1:0] hwdata,
    input  logic              hready,
    input  logic              hresp,
    input  logic [DATA_W-1:0] hrdata
);
    localparam int BIT_CYC = CLK_MHZ * 1_000_000 / BAUD;
    localparam int CW      = $clog2(BIT_CYC + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_st_t;
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_AHB_A, S_AHB_D, S_RESP} st_t;

    // ---------------- receiver ----------------
    logic          rx_meta_q, rx_sync_q, rx_prev_q;
    rx_st_t        rx_st_q, rx_st_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_sh_q, rx_sh_d;
    logic          rx_valid_q, rx_valid_d;
    logic          rx_ferr_q, rx_ferr_d;

    always_comb begin
        rx_st_d    = rx_st_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_sh_d    = rx_sh_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;
        case (rx_st_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_st_d  = RX_START;
                    rx_cnt_d = CW'(BIT_CYC / 2 - 1);
                end
            end
            RX_START: begin
                if (rx_cnt_q == '0) begin
                    // still low at mid start bit: real frame, otherwise a glitch
                    if (!rx_sync_q) begin
                        rx_st_d  = RX_DATA;
                        rx_cnt_d = CW'(BIT_CYC - 1);
                        rx_bit_d = 3'd0;
                    end else begin
                        rx_st_d = RX_IDLE;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == '0) begin
                    rx_sh_d  = {rx_sync_q, rx_sh_q[7:1]};
                    rx_cnt_d = CW'(BIT_CYC - 1);
                    if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
                    else                  rx_bit_d = rx_bit_q + 3'd1;
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
            default: begin
                if (rx_cnt_q == '0) begin
                    rx_st_d    = RX_IDLE;
                    rx_valid_d = rx_sync_q;
                    rx_ferr_d  = !rx_sync_q;
                end else begin
                    rx_cnt_d = rx_cnt_q - 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_st_q    <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= 3'd0;
            rx_sh_q    <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_meta_q  <= rx_pin;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_st_q    <= rx_st_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_sh_q    <= rx_sh_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    // ---------------- transmitter ----------------
    // Response bytes wait in resp_buf_q (low byte first); the shifter takes the next one
    // in the same cycle the previous stop bit ends, so consecutive bytes have no gap.
    logic [DATA_W+7:0] resp_buf_q;
    logic [2:0]        resp_cnt_q;
    logic [9:0]        tx_sh_q, tx_sh_d;
    logic [CW-1:0]     tx_cnt_q, tx_cnt_d;
    logic [3:0]        tx_bit_q, tx_bit_d;
    logic              tx_busy_q, tx_busy_d;
    logic              tx_take;

    assign tx_take = (resp_cnt_q != 3'd0) &&
                     (!tx_busy_q || (tx_cnt_q == '0 && tx_bit_q == 4'd0));

    always_comb begin
        tx_sh_d   = tx_sh_q;
        tx_cnt_d  = tx_cnt_q;
        tx_bit_d  = tx_bit_q;
        tx_busy_d = tx_busy_q;
        if (tx_busy_q) begin
            if (tx_cnt_q == '0) begin
                tx_sh_d  = {1'b1, tx_sh_q[9:1]};
                tx_cnt_d = CW'(BIT_CYC - 1);
                if (tx_bit_q == 4'd0) tx_busy_d = 1'b0;
                else                  tx_bit_d  = tx_bit_q - 4'd1;
            end else begin
                tx_cnt_d = tx_cnt_q - 1'b1;
            end
        end
        if (tx_take) begin
            tx_sh_d   = {1'b1, resp_buf_q[7:0], 1'b0};
            tx_cnt_d  = CW'(BIT_CYC - 1);
            tx_bit_d  = 4'd9;
            tx_busy_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_sh_q   <= '1;
            tx_cnt_q  <= '0;
            tx_bit_q  <= 4'd0;
            tx_busy_q <= 1'b0;
        end else begin
            tx_sh_q   <= tx_sh_d;
            tx_cnt_q  <= tx_cnt_d;
            tx_bit_q  <= tx_bit_d;
            tx_busy_q <= tx_busy_d;
        end
    end

    assign tx_pin = tx_sh_q[0];

    // ---------------- command FSM ----------------
    st_t               st_q;
    logic              is_wr_q;
    logic [1:0]        byte_idx_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              hsel_q, hwrite_q;
    logic [ADDR_W-1:0] haddr_q;
    logic [DATA_W-1:0] hwdata_q;
`ifdef UART_BRIDGE_TIMEOUT_EN
    localparam int TO_CYC = 16 * BIT_CYC;
    localparam int TW     = $clog2(TO_CYC + 1);
    logic [TW-1:0] to_cnt_q;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st_q       <= S_IDLE;
            is_wr_q    <= 1'b0;
            byte_idx_q <= 2'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            hsel_q     <= 1'b0;
            hwrite_q   <= 1'b0;
            haddr_q    <= '0;
            hwdata_q   <= '0;
            resp_buf_q <= '0;
            resp_cnt_q <= 3'd0;
`ifdef UART_BRIDGE_TIMEOUT_EN
            to_cnt_q   <= TW'(TO_CYC - 1);
`endif
        end else begin
            if (tx_take) begin
                resp_buf_q <= resp_buf_q >> 8;
                resp_cnt_q <= resp_cnt_q - 3'd1;
            end
            case (st_q)
                S_IDLE: begin
                    if (rx_valid_q) begin
                        byte_idx_q <= 2'd0;
                        if (rx_sh_q == 8'hA5) begin
                            is_wr_q <= 1'b1;
                            st_q    <= S_ADDR;
                        end else if (rx_sh_q == 8'h5A) begin
                            is_wr_q <= 1'b0;
                            st_q    <= S_ADDR;
                        end else begin
                            resp_buf_q <= {{DATA_W{1'b0}}, 8'h45};
                            resp_cnt_q <= 3'd1;
                        end
                    end
                end
                S_ADDR: begin
                    if (rx_ferr_q) begin
                        st_q <= S_IDLE;
                    end else if (rx_valid_q) begin
                        addr_q     <= {rx_sh_q, addr_q[ADDR_W-1:8]};
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            if (is_wr_q) begin
                                st_q <= S_WDATA;
                            end else begin
                                st_q     <= S_AHB_A;
                                hsel_q   <= 1'b1;
                                hwrite_q <= 1'b0;
                                haddr_q  <= {rx_sh_q, addr_q[ADDR_W-1:8]};
                            end
                        end
                    end
                end
                S_WDATA: begin
                    if (rx_ferr_q) begin
                        st_q <= S_IDLE;
                    end else if (rx_valid_q) begin
                        wdata_q    <= {rx_sh_q, wdata_q[DATA_W-1:8]};
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (byte_idx_q == 2'd3) begin
                            st_q     <= S_AHB_A;
                            hsel_q   <= 1'b1;
                            hwrite_q <= 1'b1;
                            haddr_q  <= addr_q;
                        end
                    end
                end
                S_AHB_A: begin
                    hsel_q <= 1'b0;
                    if (is_wr_q) hwdata_q <= wdata_q;
                    st_q <= S_AHB_D;
                end
                S_AHB_D: begin
                    if (hready) begin
                        resp_buf_q <= {(hresp ? {DATA_W{1'b0}} : hrdata),
                                       (hresp ? 8'h45 : 8'h4B)};
                        resp_cnt_q <= is_wr_q ? 3'd1 : 3'd5;
                        st_q       <= S_RESP;
                    end
                end
                default: begin
                    if (resp_cnt_q == 3'd0 && !tx_busy_q) st_q <= S_IDLE;
                end
            endcase
`ifdef UART_BRIDGE_TIMEOUT_EN
            // counts only while the line is quiet between bytes of a partial packet
            if ((st_q == S_ADDR || st_q == S_WDATA) && rx_st_q == RX_IDLE &&
                !rx_valid_q && !rx_ferr_q) begin
                if (to_cnt_q == '0) st_q <= S_IDLE;
                else                to_cnt_q <= to_cnt_q - 1'b1;
            end else begin
                to_cnt_q <= TW'(TO_CYC - 1);
            end
`endif
        end
    end

    assign hsel   = hsel_q;
    assign hwrite = hwrite_q;
    assign haddr  = haddr_q;
    assign hwdata = hwdata_q;

endmodule

// File: tb/tb_uart_ahb_bridge.sv
module tb_uart_ahb_bridge;
    localparam int CLK_MHZ = 1;
    localparam int BAUD    = 100_000;
    localparam int BIT_CYC = 10;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        rx_pin = 1'b1;
    logic        tx_pin;
    logic        hsel, hwrite;
    logic [31:0] haddr, hwdata;
    logic        hready = 1'b1;
    logic        hresp = 1'b0;
    logic [31:0] hrdata = 32'h0;

    uart_ahb_bridge #(.CLK_MHZ(CLK_MHZ), .BAUD(BAUD), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rstn(rstn), .rx_pin(rx_pin), .tx_pin(tx_pin),
        .hsel(hsel), .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata),
        .hready(hready), .hresp(hresp), .hrdata(hrdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_t;

    bus_t        exp_bus[$];
    logic [7:0]  exp_tx[$];
    int          checks = 0;
    int          errors = 0;
    int          s_waits = 0;
    logic        s_err = 1'b0;
    logic [31:0] s_rdata = 32'h0;
    bit          tx_mon_busy = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    task automatic tick(input int n, inout bit ab);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!rstn) ab = 1'b1;
        end
    endtask

    // AHB slave responder and bus monitor
    initial begin : bus_mon
        bus_t e;
        bit   ab;
        forever begin
            @(negedge clk);
            if (rstn && hsel === 1'b1) begin
                hrdata = s_rdata;
                hresp  = s_err;
                hready = (s_waits == 0);
                if (exp_bus.size() == 0) begin
                    e = '0;
                    checks++;
                    errors++;
                    $display("FAIL unexpected_hsel: got haddr %h expected no transfer", haddr);
                end else begin
                    e = exp_bus.pop_front();
                    chk("hwrite", {31'b0, hwrite}, {31'b0, e.wr});
                    chk("haddr", haddr, e.addr);
                end
                ab = 1'b0;
                tick(1, ab);
                if (!ab) begin
                    chk("hsel_one_cycle", {31'b0, hsel}, 32'd0);
                    if (e.wr) chk("hwdata", hwdata, e.wdata);
                end
                if (!ab) tick(s_waits, ab);
                hready = 1'b1;
                if (!ab) @(negedge clk);
                hresp = 1'b0;
            end
        end
    end

    // serial response decoder
    initial begin : tx_mon
        logic [7:0] b;
        logic       st;
        bit         ab;
        forever begin
            @(negedge clk);
            if (rstn && tx_pin === 1'b0) begin
                tx_mon_busy = 1'b1;
                ab = 1'b0;
                tick(BIT_CYC / 2, ab);
                if (!ab) chk("tx_start", {31'b0, tx_pin}, 32'd0);
                for (int k = 0; k < 8; k++) begin
                    tick(BIT_CYC, ab);
                    b[k] = tx_pin;
                end
                tick(BIT_CYC, ab);
                st = tx_pin;
                if (!ab) begin
                    if (exp_tx.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_tx: got %h expected no byte", b);
                    end else begin
                        chk("tx_byte", {24'b0, b}, {24'b0, exp_tx.pop_front()});
                        chk("tx_stop", {31'b0, st}, 32'd1);
                    end
                end
                tx_mon_busy = 1'b0;
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        rx_pin = 1'b0;
        repeat (BIT_CYC) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            rx_pin = b[k];
            repeat (BIT_CYC) @(negedge clk);
        end
        rx_pin = stop;
        repeat (BIT_CYC) @(negedge clk);
        rx_pin = 1'b1;
    endtask

    task automatic send_pkt(input logic [7:0] p [9], input int n);
        for (int i = 0; i < n; i++) send_byte(p[i], 1'b1);
    endtask

    task automatic push_bus(input logic wr, input logic [31:0] a, input logic [31:0] d);
        bus_t e;
        e.wr = wr;
        e.addr = a;
        e.wdata = d;
        exp_bus.push_back(e);
    endtask

    task automatic push_tx5(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input logic [7:0] b4);
        exp_tx.push_back(b0);
        exp_tx.push_back(b1);
        exp_tx.push_back(b2);
        exp_tx.push_back(b3);
        exp_tx.push_back(b4);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_bus.size() != 0 || exp_tx.size() != 0 || tx_mon_busy) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 4000) begin
            errors++;
            $display("FAIL %s_drain: got %0d bus and %0d tx pending expected 0",
                     name, exp_bus.size(), exp_tx.size());
        end
        repeat (2 * BIT_CYC) @(negedge clk);
    endtask

    task automatic pulse_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin : watchdog
        #900_000;
        $display("FAIL watchdog: got no finish expected finish within 90000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n;
        #1 rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx_pin", {31'b0, tx_pin}, 32'd1);
        chk("rst_hsel",   {31'b0, hsel}, 32'd0);
        chk("rst_hwrite", {31'b0, hwrite}, 32'd0);
        chk("rst_haddr",  haddr, 32'h0);
        chk("rst_hwdata", hwdata, 32'h0);
        rstn = 1'b1;
        repeat (5) @(negedge clk);

        // write, no wait states
        s_waits = 0; s_err = 1'b0; s_rdata = 32'h0;
        push_bus(1'b1, 32'h0000_0100, 32'h1234_5678);
        exp_tx.push_back(8'h4B);
        send_pkt('{8'hA5, 8'h00, 8'h01, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12}, 9);
        wait_drain("write");

        // read with 3 wait states
        s_waits = 3; s_err = 1'b0; s_rdata = 32'hF6CC_AAE7;
        push_bus(1'b0, 32'h70F0_F0F0, 32'h0);
        push_tx5(8'h4B, 8'hE7, 8'hAA, 8'hCC, 8'hF6);
        send_pkt('{8'h5A, 8'hF0, 8'hF0, 8'hF0, 8'h70, 8'h00, 8'h00, 8'h00, 8'h00}, 5);
        wait_drain("read_wait");

        // write with error response
        s_waits = 2; s_err = 1'b1; s_rdata = 32'h0;
        push_bus(1'b1, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        exp_tx.push_back(8'h45);
        send_pkt('{8'hA5, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h0D, 8'hF0, 8'hFE, 8'hCA}, 9);
        wait_drain("write_err");

        // read with error response: data bytes forced to zero
        s_waits = 1; s_err = 1'b1; s_rdata = 32'h9999_9999;
        push_bus(1'b0, 32'h0000_0004, 32'h0);
        push_tx5(8'h45, 8'h00, 8'h00, 8'h00, 8'h00);
        send_pkt('{8'h5A, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 5);
        wait_drain("read_err");

        // bad opcode, then a normal read
        exp_tx.push_back(8'h45);
        send_byte(8'h33, 1'b1);
        wait_drain("bad_opcode");
        s_waits = 0; s_err = 1'b0; s_rdata = 32'h0102_0304;
        push_bus(1'b0, 32'h0000_0010, 32'h0);
        push_tx5(8'h4B, 8'h04, 8'h03, 8'h02, 8'h01);
        send_pkt('{8'h5A, 8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 5);
        wait_drain("after_bad_opcode");

        // framing error after opcode aborts the packet silently
        send_byte(8'hA5, 1'b1);
        send_byte(8'h12, 1'b0);
        repeat (3 * BIT_CYC) @(negedge clk);
        s_waits = 2; s_err = 1'b0; s_rdata = 32'hA1B2_C3D4;
        push_bus(1'b0, 32'h0000_0020, 32'h0);
        push_tx5(8'h4B, 8'hD4, 8'hC3, 8'hB2, 8'hA1);
        send_pkt('{8'h5A, 8'h20, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 5);
        wait_drain("after_framing");

        // short low glitch on rx is ignored
        @(negedge clk);
        rx_pin = 1'b0;
        repeat (3) @(negedge clk);
        rx_pin = 1'b1;
        repeat (15 * BIT_CYC) @(negedge clk);
        s_waits = 0; s_err = 1'b0;
        push_bus(1'b1, 32'h0000_0044, 32'h1122_3344);
        exp_tx.push_back(8'h4B);
        send_pkt('{8'hA5, 8'h44, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11}, 9);
        wait_drain("after_glitch");

        // reset while waiting in the data phase
        s_waits = 40; s_err = 1'b0; s_rdata = 32'h1357_9BDF;
        push_bus(1'b0, 32'h0000_0008, 32'h0);
        send_pkt('{8'h5A, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 5);
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("rst_ahbd_hsel", {31'b0, hsel}, 32'd0);
        chk("rst_ahbd_tx_pin", {31'b0, tx_pin}, 32'd1);
        chk("rst_ahbd_haddr", haddr, 32'h0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (5 * BIT_CYC) @(negedge clk);
        chk("rst_ahbd_bus_seen", 32'(exp_bus.size()), 32'd0);

        // reset while a response byte is on the wire
        s_waits = 0; s_err = 1'b0; s_rdata = 32'h55AA_55AA;
        push_bus(1'b0, 32'h0000_000C, 32'h0);
        send_pkt('{8'h5A, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 5);
        n = 0;
        while (tx_pin !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("resp_tx_started", {31'b0, tx_pin}, 32'd0);
        // land inside data bit 2 of 0x4B, which is a 0
        repeat (34) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("rst_resp_tx_pin", {31'b0, tx_pin}, 32'd1);
        chk("rst_resp_hsel", {31'b0, hsel}, 32'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (15 * BIT_CYC) @(negedge clk);

`ifdef UART_BRIDGE_TIMEOUT_EN
        // partial packet followed by a long idle gap is dropped
        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        repeat (17 * BIT_CYC) @(negedge clk);
        s_waits = 0; s_err = 1'b0;
        push_bus(1'b1, 32'h0000_0200, 32'hA5A5_5A5A);
        exp_tx.push_back(8'h4B);
        send_pkt('{8'hA5, 8'h00, 8'h02, 8'h00, 8'h00, 8'h5A, 8'h5A, 8'hA5, 8'hA5}, 9);
        wait_drain("after_timeout");
`endif

        // normal operation after the resets
        s_waits = 1; s_err = 1'b0;
        push_bus(1'b1, 32'h8000_0000, 32'hDEAD_BEEF);
        exp_tx.push_back(8'h4B);
        send_pkt('{8'hA5, 8'h00, 8'h00, 8'h00, 8'h80, 8'hEF, 8'hBE, 8'hAD, 8'hDE}, 9);
        wait_drain("after_reset");

        repeat (30 * BIT_CYC) @(negedge clk);
        chk("bus_queue_empty", 32'(exp_bus.size()), 32'd0);
        chk("tx_queue_empty", 32'(exp_tx.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
